parking_session_ctrl: RTL and testbench
=======================================

Name: parking_session_ctrl

Overview:
- Clocked successor to the combinational parking/charging main circuit.
- Manages N_SLOTS parking/charging bays and runs each bay's session end to end: password authentication with lockout, slot entry, per-slot hour metering, fee computation (normal or fast-charge rate), cash/card payment handshake, and fire-alarm override.
- Sits between the user keypad/payment front end and the gate/alarm actuators.

Parameters:
N_SLOTS, 4, number of bays
SLOT_W, 2, slot index width (clog2 N_SLOTS)
HOUR_W, 4, metered-hours width; saturates at 2^HOUR_W-1
PRICE_W, 8, fee/cash width
TICKS_PER_HOUR, 16, clk cycles per billed hour
RATE_NORMAL, 1, price per hour, normal bay use
RATE_FAST, 2, price per hour, fast-charge use
PASSWORD, 4'b1101, access code
MAX_TRIES, 3, consecutive wrong passwords before lockout
LOCK_CYCLES, 32, lockout duration in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pw_valid  in  1  pw_in valid strobe
pw_in  in  4  entered password
enter_req  in  1  request to occupy slot_sel
exit_req  in  1  request to release slot_sel
slot_sel  in  SLOT_W  target slot
fast_charge  in  1  sampled with enter_req; selects RATE_FAST for that session
pay_valid  in  1  payment strobe
pay_mode  in  1  0 = cash, 1 = card
pay_amount  in  PRICE_W  cash tendered
card_ok  in  1  card authorisation result, sampled with pay_valid
fire_in  in  N_SLOTS  per-slot fire detector
alarm_clr  in  1  operator clear of latched alarm
auth_ok  out  1  high while authenticated
locked  out  1  high during lockout
ack  out  1  1-cycle pulse: request accepted
nack  out  1  1-cycle pulse: request rejected or payment failed
occupancy  out  N_SLOTS  slot occupied flags
fee  out  PRICE_W  computed fee, valid in PAY
paid_cash  out  1  1-cycle pulse
paid_card  out  1  1-cycle pulse
change  out  PRICE_W  pay_amount - fee; held until next payment
gate_open  out  1  pulse on entry/exit; level high in ALARM
alarm_status  out  N_SLOTS  latched fire flags

Behaviour:
- Reset: all outputs 0, state IDLE, fail count 0, all slot timers cleared. Reset mid-session abandons that session and frees the slot.
- FSM states: IDLE, AUTH, BILL, PAY, LOCK, ALARM. All outputs registered.
- IDLE:
  - pw_valid with pw_in==PASSWORD -> AUTH next cycle; auth_ok=1; fail count cleared.
  - pw_valid with a mismatch -> nack pulse and fail count +1.
  - Fail count reaching MAX_TRIES -> LOCK; count cleared.
- LOCK: locked=1; pw_valid ignored, no nack. After LOCK_CYCLES cycles -> IDLE.
- AUTH: one transaction, then return to IDLE (auth_ok=0).
  - enter_req on a free slot: set occupancy bit, latch rate from fast_charge, clear and start the slot timer; ack and gate_open pulse; -> IDLE.
  - enter_req on an occupied slot -> nack; stay in AUTH.
  - exit_req on an occupied slot -> BILL. On a free slot -> nack; stay in AUTH.
  - enter_req and exit_req in the same cycle -> nack; no change.
- Slot timer, one per slot:
  - Tick counter increments while occupied.
  - At TICKS_PER_HOUR-1 the tick counter wraps and hours increments.
  - hours saturates at 2^HOUR_W-1.
  - Timers keep running in every state, including ALARM.
- BILL (1 cycle): billed_hours = max(hours,1); fee = billed_hours*rate computed at full width, then saturated to 2^PRICE_W-1 -> PAY. The slot timer is frozen from BILL entry.
- PAY: waits for pay_valid.
  - Cash with pay_amount >= fee: paid_cash pulse, change = pay_amount - fee.
  - Card with card_ok=1: paid_card pulse, change = 0.
  - On either success: clear occupancy and timer, gate_open pulse, -> IDLE.
  - Otherwise (insufficient cash or card_ok=0): nack; stay in PAY; fee is held.
- ALARM:
  - Entry: any fire_in bit set, from any state including LOCK. Takes priority over every other input that cycle.
  - alarm_status |= fire_in on every cycle.
  - gate_open held at 1; auth_ok cleared; an in-progress BILL/PAY is aborted and the slot stays occupied with its timer resumed.
  - Exit: fire_in==0 and alarm_clr in the same cycle -> alarm_status cleared, -> IDLE.
  - alarm_clr while any fire_in bit is set is ignored.
- slot_sel >= N_SLOTS -> nack.

Decomposition:
- Shared package parking_pkg:
  - State enum.
  - Pay-mode constants: PAY_CASH=0, PAY_CARD=1.
  - Default rate/threshold constants: RATE_NORMAL, RATE_FAST, PASSWORD.
- Sub-module slot_timer, one instance per slot: inputs clk, rst, start, run, clear; outputs hours[HOUR_W] and rate_sel.

Test Plan:
- Auth and lockout: pw_in=1100 three times -> nack x3, locked=1 for 32 cycles; then pw_in=1101 -> auth_ok=1.
- Normal session: auth, enter slot 2 with fast_charge=0 -> ack, gate_open pulse, occupancy=0100. Wait 48 cycles (hours=3), exit slot 2 -> fee=3. Cash 8'h80 -> paid_cash, change=8'h7D, occupancy=0000.
- Fast charge, minimum bill, failed payment: enter slot 0 with fast_charge=1, exit after 5 cycles -> fee=2. Card with card_ok=0 -> nack, state stays PAY. Card with card_ok=1 -> paid_card.
- Occupied/invalid requests: enter an occupied slot -> nack; exit a free slot -> nack; simultaneous enter_req and exit_req -> nack; occupancy unchanged in all three.
- Fire override: fire_in=8'b0100-style pattern 0010 during PAY -> ALARM, gate_open=1, alarm_status=0010, slot stays occupied. alarm_clr with fire_in still set -> ignored. fire_in=0 plus alarm_clr -> IDLE, alarm_status=0.
- Saturation and reset: hold a session for 300 cycles -> hours=15. Assert rst mid-PAY -> all outputs 0, occupancy 0.

Source files
------------

// File: rtl/parking_session_ctrl_pkg.sv
// Shared definitions for the parking/charging session controller:
// FSM state encodings, payment modes, default rates and the fee helper.
package parking_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_AUTH  = 3'd1;
  localparam state_t ST_BILL  = 3'd2;
  localparam state_t ST_PAY   = 3'd3;
  localparam state_t ST_LOCK  = 3'd4;
  localparam state_t ST_ALARM = 3'd5;

  localparam logic PAY_CASH = 1'b0;
  localparam logic PAY_CARD = 1'b1;

  localparam int         RATE_NORMAL = 1;
  localparam int         RATE_FAST   = 2;
  localparam logic [3:0] PASSWORD    = 4'b1101;

  // A session is always billed for at least one hour; result clamps to max_fee.
  function automatic int unsigned bill_fee(input int unsigned hours,
                                           input int unsigned rate,
                                           input int unsigned max_fee);
    int unsigned billed;
    int unsigned full;
    billed = (hours == 32'd0) ? 32'd1 : hours;
    full   = billed * rate;
    return (full > max_fee) ? max_fee : full;
  endfunction

endpackage

// File: rtl/parking_session_ctrl_slot_timer.sv
// Per-bay hour meter: counts clock ticks into saturating billed hours and
// remembers which rate the session was opened with.
module slot_timer #(
  parameter int HOUR_W         = 4,
  parameter int TICKS_PER_HOUR = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              clear,
  input  logic              fast_charge,
  output logic [HOUR_W-1:0] hours,
  output logic              rate_sel
);

  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

  logic [TICK_W-1:0] ticks;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ticks    <= '0;
      hours    <= '0;
      rate_sel <= 1'b0;
    end else if (start) begin
      ticks    <= '0;
      hours    <= '0;
      rate_sel <= fast_charge;
    end else if (run) begin
      if (ticks == TICK_W'(TICKS_PER_HOUR - 1)) begin
        ticks <= '0;
        if (hours != '1) hours <= hours + HOUR_W'(1);
      end else begin
        ticks <= ticks + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/parking_session_ctrl.sv
// Session controller for N_SLOTS parking/charging bays: password access with
// lockout, entry, metering, billing, payment and fire-alarm override.
module parking_session_ctrl #(
  parameter int         N_SLOTS        = 4,
  parameter int         SLOT_W         = 2,
  parameter int         HOUR_W         = 4,
  parameter int         PRICE_W        = 8,
  parameter int         TICKS_PER_HOUR = 16,
  parameter int         RATE_NORMAL    = parking_pkg::RATE_NORMAL,
  parameter int         RATE_FAST      = parking_pkg::RATE_FAST,
  parameter logic [3:0] PASSWORD       = parking_pkg::PASSWORD,
  parameter int         MAX_TRIES      = 3,
  parameter int         LOCK_CYCLES    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pw_valid,
  input  logic [3:0]         pw_in,
  input  logic               enter_req,
  input  logic               exit_req,
  input  logic [SLOT_W-1:0]  slot_sel,
  input  logic               fast_charge,
  input  logic               pay_valid,
  input  logic               pay_mode,
  input  logic [PRICE_W-1:0] pay_amount,
  input  logic               card_ok,
  input  logic [N_SLOTS-1:0] fire_in,
  input  logic               alarm_clr,
  output logic               auth_ok,
  output logic               locked,
  output logic               ack,
  output logic               nack,
  output logic [N_SLOTS-1:0] occupancy,
  output logic [PRICE_W-1:0] fee,
  output logic               paid_cash,
  output logic               paid_card,
  output logic [PRICE_W-1:0] change,
  output logic               gate_open,
  output logic [N_SLOTS-1:0] alarm_status
);

  import parking_pkg::*;

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t            state;
  logic [FAIL_W-1:0] fail_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [SLOT_W-1:0] cur_slot;

  logic               fire_any, slot_ok, sel_occ;
  logic               do_enter, do_exit, cash_hit, card_hit, pay_done;
  logic [N_SLOTS-1:0] start_vec, run_vec, clear_vec, rate_arr;
  logic [HOUR_W-1:0]  hours_arr [N_SLOTS];
  int unsigned        fee_full;
  logic [PRICE_W-1:0] fee_next;

  // Decisions shared by the FSM and the slot timers so both see the same event.
  always_comb begin
    fire_any = |fire_in;
    slot_ok  = (32'(slot_sel) < 32'(N_SLOTS));
    sel_occ  = slot_ok && occupancy[slot_sel];
    do_enter = (state == ST_AUTH) && !fire_any && enter_req && !exit_req && slot_ok && !sel_occ;
    do_exit  = (state == ST_AUTH) && !fire_any && exit_req && !enter_req && sel_occ;
    cash_hit = (state == ST_PAY) && !fire_any && pay_valid && (pay_mode == PAY_CASH) &&
               (pay_amount >= fee);
    card_hit = (state == ST_PAY) && !fire_any && pay_valid && (pay_mode == PAY_CARD) && card_ok;
    pay_done = cash_hit || card_hit;
    fee_full = bill_fee(32'(hours_arr[cur_slot]),
                        rate_arr[cur_slot] ? 32'(RATE_FAST) : 32'(RATE_NORMAL),
                        32'({PRICE_W{1'b1}}));
    fee_next = PRICE_W'(fee_full);
    for (int i = 0; i < N_SLOTS; i++) begin
      start_vec[i] = do_enter && (32'(slot_sel) == 32'(i));
      clear_vec[i] = pay_done && (32'(cur_slot) == 32'(i));
      // The exiting bay stops metering while its bill is being settled.
      run_vec[i]   = occupancy[i] &&
                     !(((state == ST_BILL) || (state == ST_PAY)) && (32'(cur_slot) == 32'(i)));
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    slot_timer #(
      .HOUR_W        (HOUR_W),
      .TICKS_PER_HOUR(TICKS_PER_HOUR)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (start_vec[g]),
      .run        (run_vec[g]),
      .clear      (clear_vec[g]),
      .fast_charge(fast_charge),
      .hours      (hours_arr[g]),
      .rate_sel   (rate_arr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      fail_cnt     <= '0;
      lock_cnt     <= '0;
      cur_slot     <= '0;
      auth_ok      <= 1'b0;
      locked       <= 1'b0;
      ack          <= 1'b0;
      nack         <= 1'b0;
      occupancy    <= '0;
      fee          <= '0;
      paid_cash    <= 1'b0;
      paid_card    <= 1'b0;
      change       <= '0;
      gate_open    <= 1'b0;
      alarm_status <= '0;
    end else begin
      ack       <= 1'b0;
      nack      <= 1'b0;
      paid_cash <= 1'b0;
      paid_card <= 1'b0;
      gate_open <= 1'b0;
      // Fire overrides everything, whatever state we were in.
      if (fire_any) begin
        state        <= ST_ALARM;
        alarm_status <= alarm_status | fire_in;
        gate_open    <= 1'b1;
        auth_ok      <= 1'b0;
        locked       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pw_valid) begin
              if (pw_in == PASSWORD) begin
                state    <= ST_AUTH;
                auth_ok  <= 1'b1;
                fail_cnt <= '0;
              end else begin
                nack <= 1'b1;
                if (fail_cnt == FAIL_W'(MAX_TRIES - 1)) begin
                  state    <= ST_LOCK;
                  locked   <= 1'b1;
                  lock_cnt <= '0;
                  fail_cnt <= '0;
                end else begin
                  fail_cnt <= fail_cnt + FAIL_W'(1);
                end
              end
            end
          end
          ST_LOCK: begin
            if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
              state  <= ST_IDLE;
              locked <= 1'b0;
            end else begin
              lock_cnt <= lock_cnt + LOCK_W'(1);
            end
          end
          ST_AUTH: begin
            if (do_enter) begin
              occupancy[slot_sel] <= 1'b1;
              ack       <= 1'b1;
              gate_open <= 1'b1;
              auth_ok   <= 1'b0;
              state     <= ST_IDLE;
            end else if (do_exit) begin
              cur_slot <= slot_sel;
              auth_ok  <= 1'b0;
              state    <= ST_BILL;
            end else if (enter_req || exit_req) begin
              nack <= 1'b1;
            end
          end
          ST_BILL: begin
            fee   <= fee_next;
            state <= ST_PAY;
          end
          ST_PAY: begin
            if (pay_done) begin
              paid_cash           <= cash_hit;
              paid_card           <= card_hit;
              change              <= cash_hit ? (pay_amount - fee) : '0;
              occupancy[cur_slot] <= 1'b0;
              gate_open           <= 1'b1;
              state               <= ST_IDLE;
            end else if (pay_valid) begin
              nack <= 1'b1;
            end
          end
          ST_ALARM: begin
            if (alarm_clr) begin
              alarm_status <= '0;
              state        <= ST_IDLE;
            end else begin
              gate_open <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Directed bench for parking_session_ctrl: a vector table for single-cycle
// requests plus hand sequences for lockout, sessions, alarm and saturation.
module tb_parking_session_ctrl;

  logic       clk = 1'b0;
  logic       rst, pw_valid, enter_req, exit_req, fast_charge;
  logic       pay_valid, pay_mode, card_ok, alarm_clr;
  logic [3:0] pw_in, fire_in;
  logic [1:0] slot_sel;
  logic [7:0] pay_amount;
  logic       auth_ok, locked, ack, nack, paid_cash, paid_card, gate_open;
  logic [3:0] occupancy, alarm_status;
  logic [7:0] fee, change;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_session_ctrl dut (
    .clk(clk), .rst(rst), .pw_valid(pw_valid), .pw_in(pw_in),
    .enter_req(enter_req), .exit_req(exit_req), .slot_sel(slot_sel),
    .fast_charge(fast_charge), .pay_valid(pay_valid), .pay_mode(pay_mode),
    .pay_amount(pay_amount), .card_ok(card_ok), .fire_in(fire_in),
    .alarm_clr(alarm_clr), .auth_ok(auth_ok), .locked(locked), .ack(ack),
    .nack(nack), .occupancy(occupancy), .fee(fee), .paid_cash(paid_cash),
    .paid_card(paid_card), .change(change), .gate_open(gate_open),
    .alarm_status(alarm_status)
  );

  typedef struct {
    logic       rst;
    logic       pw_valid;
    logic [3:0] pw_in;
    logic       enter_req;
    logic       exit_req;
    logic [1:0] slot;
    logic       fast;
    logic       exp_auth;
    logic       exp_locked;
    logic       exp_ack;
    logic       exp_nack;
    logic       exp_gate;
    logic [3:0] exp_occ;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    rst = 1'b0; pw_valid = 1'b0; pw_in = 4'd0; enter_req = 1'b0; exit_req = 1'b0;
    slot_sel = 2'd0; fast_charge = 1'b0; pay_valid = 1'b0; pay_mode = 1'b0;
    pay_amount = 8'd0; card_ok = 1'b0; fire_in = 4'd0; alarm_clr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    zero_inputs();
    rst = v.rst; pw_valid = v.pw_valid; pw_in = v.pw_in; enter_req = v.enter_req;
    exit_req = v.exit_req; slot_sel = v.slot; fast_charge = v.fast;
    step();
  endtask

  task automatic do_idle(input int n);
    repeat (n) begin
      zero_inputs();
      step();
    end
  endtask

  task automatic do_reset();
    zero_inputs(); rst = 1'b1; step();
  endtask

  task automatic do_pw(input logic [3:0] p);
    zero_inputs(); pw_valid = 1'b1; pw_in = p; step();
  endtask

  task automatic do_enter(input logic [1:0] s, input logic f);
    zero_inputs(); enter_req = 1'b1; slot_sel = s; fast_charge = f; step();
  endtask

  task automatic do_exit(input logic [1:0] s);
    zero_inputs(); exit_req = 1'b1; slot_sel = s; step();
  endtask

  task automatic do_pay(input logic m, input logic [7:0] a, input logic ok);
    zero_inputs(); pay_valid = 1'b1; pay_mode = m; pay_amount = a; card_ok = ok; step();
  endtask

  task automatic do_fire(input logic [3:0] f, input logic clr);
    zero_inputs(); fire_in = f; alarm_clr = clr; step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            rst   pv    pw       en    ex    slot  fast  auth  lock  ack   nack  gate  occ
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010};
    vecs[3]  = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1010};
    vecs[9]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010};
    vecs[10] = '{1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[11] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

    zero_inputs();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d auth_ok", i), auth_ok, vecs[i].exp_auth);
      checkOutput($sformatf("v%0d locked", i), locked, vecs[i].exp_locked);
      checkOutput($sformatf("v%0d ack", i), ack, vecs[i].exp_ack);
      checkOutput($sformatf("v%0d nack", i), nack, vecs[i].exp_nack);
      checkOutput($sformatf("v%0d gate_open", i), gate_open, vecs[i].exp_gate);
      checkOutput($sformatf("v%0d occupancy", i), occupancy, vecs[i].exp_occ);
    end
    checkOutput("reset fee", fee, 32'h0);
    checkOutput("reset alarm_status", alarm_status, 32'h0);

    // Three wrong codes lock the keypad for 32 cycles, ignoring correct codes.
    for (int i = 0; i < 3; i++) begin
      do_pw(4'b1100);
      checkOutput($sformatf("wrong pw %0d nack", i), nack, 32'h1);
      checkOutput($sformatf("wrong pw %0d locked", i), locked, (i == 2) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 31; i++) begin
      do_pw(4'b1101);
      checkOutput($sformatf("lock hold %0d", i), locked, 32'h1);
    end
    checkOutput("lock no nack", nack, 32'h0);
    checkOutput("lock no auth", auth_ok, 32'h0);
    do_pw(4'b1101);
    checkOutput("lock expired", locked, 32'h0);
    checkOutput("lock exit no auth", auth_ok, 32'h0);
    do_pw(4'b1101);
    checkOutput("post-lock auth_ok", auth_ok, 32'h1);
    do_reset();

    // Fast charge, minimum one-hour bill, failed then good payments.
    do_pw(4'b1101);
    do_enter(2'd0, 1'b1);
    checkOutput("fast enter ack", ack, 32'h1);
    checkOutput("fast enter occ", occupancy, 32'b0001);
    do_idle(3);
    do_pw(4'b1101);
    do_exit(2'd0);
    do_idle(1);
    checkOutput("fast fee", fee, 32'd2);
    do_pay(1'b0, 8'd1, 1'b0);
    checkOutput("short cash nack", nack, 32'h1);
    checkOutput("short cash no paid", paid_cash, 32'h0);
    do_pay(1'b1, 8'd0, 1'b0);
    checkOutput("card decline nack", nack, 32'h1);
    checkOutput("card decline paid", paid_card, 32'h0);
    checkOutput("card decline occ", occupancy, 32'b0001);
    checkOutput("card decline fee held", fee, 32'd2);
    do_pay(1'b1, 8'd0, 1'b1);
    checkOutput("card paid", paid_card, 32'h1);
    checkOutput("card change", change, 32'h0);
    checkOutput("card occ cleared", occupancy, 32'b0000);
    checkOutput("card gate", gate_open, 32'h1);
    do_idle(1);
    checkOutput("card paid pulse end", paid_card, 32'h0);
    checkOutput("card gate pulse end", gate_open, 32'h0);

    // Normal-rate session of three metered hours paid in cash.
    do_pw(4'b1101);
    do_enter(2'd2, 1'b0);
    checkOutput("normal enter ack", ack, 32'h1);
    checkOutput("normal enter gate", gate_open, 32'h1);
    checkOutput("normal enter occ", occupancy, 32'b0100);
    do_idle(48);
    do_pw(4'b1101);
    checkOutput("normal reauth", auth_ok, 32'h1);
    do_exit(2'd2);
    do_idle(1);
    checkOutput("normal fee", fee, 32'd3);
    do_pay(1'b0, 8'h80, 1'b0);
    checkOutput("cash paid", paid_cash, 32'h1);
    checkOutput("cash change", change, 32'h7D);
    checkOutput("cash occ cleared", occupancy, 32'b0000);
    checkOutput("cash gate", gate_open, 32'h1);
    do_idle(1);
    checkOutput("change held", change, 32'h7D);

    // Hours saturate at 15 on a long fast session; reset mid-PAY clears all.
    do_pw(4'b1101);
    do_enter(2'd3, 1'b1);
    do_idle(300);
    do_pw(4'b1101);
    do_exit(2'd3);
    do_idle(1);
    checkOutput("saturated fee", fee, 32'd30);
    do_pay(1'b0, 8'h10, 1'b0);
    checkOutput("sat short cash nack", nack, 32'h1);
    checkOutput("sat change held", change, 32'h7D);
    do_reset();
    checkOutput("rst occ", occupancy, 32'h0);
    checkOutput("rst fee", fee, 32'h0);
    checkOutput("rst change", change, 32'h0);
    checkOutput("rst auth", auth_ok, 32'h0);
    checkOutput("rst gate", gate_open, 32'h0);
    checkOutput("rst nack", nack, 32'h0);

    // Fire during PAY aborts billing, holds the gate, and needs a clean clear.
    do_pw(4'b1101);
    do_enter(2'd1, 1'b0);
    do_pw(4'b1101);
    do_exit(2'd1);
    do_idle(1);
    checkOutput("alarm pre fee", fee, 32'd1);
    do_fire(4'b0010, 1'b0);
    checkOutput("alarm gate", gate_open, 32'h1);
    checkOutput("alarm status", alarm_status, 32'b0010);
    checkOutput("alarm occ kept", occupancy, 32'b0010);
    do_fire(4'b0010, 1'b1);
    checkOutput("alarm clr ignored", alarm_status, 32'b0010);
    checkOutput("alarm clr gate", gate_open, 32'h1);
    do_pay(1'b0, 8'hFF, 1'b0);
    checkOutput("alarm pay ignored", paid_cash, 32'h0);
    checkOutput("alarm gate level", gate_open, 32'h1);
    checkOutput("alarm occ still", occupancy, 32'b0010);
    do_fire(4'b0000, 1'b1);
    checkOutput("alarm cleared", alarm_status, 32'h0);
    checkOutput("alarm gate closed", gate_open, 32'h0);
    do_pw(4'b1101);
    checkOutput("post alarm auth", auth_ok, 32'h1);
    do_fire(4'b1000, 1'b0);
    checkOutput("alarm drops auth", auth_ok, 32'h0);
    do_fire(4'b0100, 1'b0);
    checkOutput("alarm accumulate", alarm_status, 32'b1100);
    do_fire(4'b0000, 1'b1);
    checkOutput("alarm final clear", alarm_status, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
